// File: rtl/md_sequencer.sv
// md_sequencer: EX-stage multiply/divide sequencer owning the HI/LO registers.
// Multiplies finish after a fixed MULT_CYCLES countdown. Divides run a 32-step
// restoring shift-subtract loop followed by one FIX cycle that applies signs.
// Optional build macro: MD_SEQ_DIV0_EARLY_EN (a zero divisor skips the 32 steps).
module md_sequencer #(
    parameter int unsigned MULT_CYCLES = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic        stall,
    output logic        busy,
    output logic [31:0] rd_data,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] OpMult  = 3'd0;
    localparam logic [2:0] OpMultu = 3'd1;
    localparam logic [2:0] OpDiv   = 3'd2;
    localparam logic [2:0] OpDivu  = 3'd3;
    localparam logic [2:0] OpMthi  = 3'd4;
    localparam logic [2:0] OpMtlo  = 3'd5;
    localparam logic [2:0] OpMfhi  = 3'd6;
    localparam logic [2:0] OpMflo  = 3'd7;

    localparam logic [4:0] MulLoad = 5'(MULT_CYCLES - 1);
    localparam logic [4:0] DivLoad = 5'd31;

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;

    state_e      state_q;
    logic        busy_q;
    logic [31:0] hi_q, lo_q;
    logic [4:0]  cnt_q;
    // opa_q: multiplicand, or dividend magnitude that becomes the quotient.
    logic [31:0] opa_q, opb_q;
    logic [31:0] rem_q;
    logic [31:0] rs_q;          // rs as issued, returned in HI on divide by zero
    logic        mul_signed_q;
    logic        q_neg_q, r_neg_q;

    logic        accept;
    logic        div_signed;
    logic [31:0] rs_mag, rt_mag;
    logic [63:0] mul_a, mul_b, mul_prod;
    logic [33:0] div_trial;
    logic        div_borrow;
    logic [31:0] q_fix, r_fix;
    logic        div0;

    assign accept = op_valid && !busy_q;

    // Operand magnitudes at issue; DIVU passes raw values through.
    always_comb begin
        div_signed = (op == OpDiv);
        rs_mag     = (div_signed && rs[31]) ? (32'd0 - rs) : rs;
        rt_mag     = (div_signed && rt[31]) ? (32'd0 - rt) : rt;
    end

    // Low 64 bits of the extended product are correct for both signednesses.
    always_comb begin
        mul_a    = {{32{mul_signed_q & opa_q[31]}}, opa_q};
        mul_b    = {{32{mul_signed_q & opb_q[31]}}, opb_q};
        mul_prod = mul_a * mul_b;
    end

    // One restoring step: shift the next dividend bit into the remainder and trial-subtract.
    always_comb begin
        div_trial  = {1'b0, rem_q, opa_q[31]} - {2'b00, opb_q};
        div_borrow = div_trial[33];
    end

    // Sign correction and divide-by-zero detection for the FIX cycle.
    always_comb begin
        q_fix = q_neg_q ? (32'd0 - opa_q) : opa_q;
        r_fix = r_neg_q ? (32'd0 - rem_q) : rem_q;
        div0  = (opb_q == 32'd0);
    end

    // Sequencer FSM with registered busy and architectural HI/LO.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            busy_q       <= 1'b0;
            hi_q         <= 32'd0;
            lo_q         <= 32'd0;
            cnt_q        <= 5'd0;
            opa_q        <= 32'd0;
            opb_q        <= 32'd0;
            rem_q        <= 32'd0;
            rs_q         <= 32'd0;
            mul_signed_q <= 1'b0;
            q_neg_q      <= 1'b0;
            r_neg_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        unique case (op)
                            OpMult, OpMultu: begin
                                opa_q        <= rs;
                                opb_q        <= rt;
                                mul_signed_q <= (op == OpMult);
                                cnt_q        <= MulLoad;
                                busy_q       <= 1'b1;
                                state_q      <= StMul;
                            end
                            OpDiv, OpDivu: begin
                                opa_q   <= rs_mag;
                                opb_q   <= rt_mag;
                                rem_q   <= 32'd0;
                                rs_q    <= rs;
                                q_neg_q <= div_signed && (rs[31] ^ rt[31]);
                                r_neg_q <= div_signed && rs[31];
                                cnt_q   <= DivLoad;
                                busy_q  <= 1'b1;
`ifdef MD_SEQ_DIV0_EARLY_EN
                                state_q <= (rt == 32'd0) ? StFix : StDiv;
`else
                                state_q <= StDiv;
`endif
                            end
                            OpMthi: hi_q <= rs;
                            OpMtlo: lo_q <= rs;
                            default: ;  // MFHI/MFLO are combinational reads
                        endcase
                    end
                end
                StMul: begin
                    if (cnt_q == 5'd0) begin
                        hi_q    <= mul_prod[63:32];
                        lo_q    <= mul_prod[31:0];
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q - 5'd1;
                    end
                end
                StDiv: begin
                    opa_q <= {opa_q[30:0], ~div_borrow};
                    rem_q <= div_borrow ? {rem_q[30:0], opa_q[31]} : div_trial[31:0];
                    if (cnt_q == 5'd0) begin
                        state_q <= StFix;
                    end else begin
                        cnt_q <= cnt_q - 5'd1;
                    end
                end
                StFix: begin
                    if (div0) begin
                        hi_q <= rs_q;
                        lo_q <= 32'hFFFF_FFFF;
                    end else begin
                        hi_q <= r_fix;
                        lo_q <= q_fix;
                    end
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Zero-latency HI/LO read on an accepted MFHI/MFLO.
    always_comb begin
        rd_data = 32'd0;
        if (accept && op == OpMfhi) rd_data = hi_q;
        if (accept && op == OpMflo) rd_data = lo_q;
    end

    assign busy  = busy_q;
    assign stall = op_valid && busy_q;
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule

// File: tb/tb_md_sequencer.sv
// tb_md_sequencer: directed and randomized checks of md_sequencer against a
// cycle-count/arithmetic reference model.
module tb_md_sequencer;

    localparam int unsigned MC = 5;
`ifdef MD_SEQ_DIV0_EARLY_EN
    localparam bit Div0Early = 1'b1;
`else
    localparam bit Div0Early = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        op_valid = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] rs = 32'd0;
    logic [31:0] rt = 32'd0;
    logic        stall, busy;
    logic [31:0] rd_data, hi, lo;

    int n_checks = 0;
    int n_fail = 0;

    // Reference model: architectural HI/LO, remaining busy cycles, pending result.
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0, p_hi = 32'd0, p_lo = 32'd0;
    int          m_cnt = 0;

    md_sequencer #(.MULT_CYCLES(MC)) dut (
        .clk     (clk),
        .reset   (reset),
        .op_valid(op_valid),
        .op      (op),
        .rs      (rs),
        .rt      (rt),
        .stall   (stall),
        .busy    (busy),
        .rd_data (rd_data),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Compute the final HI/LO of a multiply or divide from plain arithmetic.
    task automatic model_result(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint          sp;
        longint unsigned up;
        int              sa, sb;
        case (o)
            3'd0: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                {p_hi, p_lo} = sp;
            end
            3'd1: begin
                up = longint'(a) * longint'(b);
                {p_hi, p_lo} = up;
            end
            3'd2: begin
                sa = $signed(a);
                sb = $signed(b);
                if (b == 32'd0) begin
                    p_hi = a; p_lo = 32'hFFFF_FFFF;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    p_hi = 32'd0; p_lo = 32'h8000_0000;
                end else begin
                    p_lo = sa / sb;
                    p_hi = sa % sb;
                end
            end
            default: begin
                if (b == 32'd0) begin
                    p_hi = a; p_lo = 32'hFFFF_FFFF;
                end else begin
                    p_lo = a / b;
                    p_hi = a % b;
                end
            end
        endcase
    endtask

    // One clock cycle: drive, check combinational/registered outputs mid-cycle, advance model.
    task automatic step(input logic v, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic r, input bit chk,
                        output logic st, output logic [31:0] rd);
        logic        e_busy;
        logic [31:0] e_rd;
        op_valid = v; op = o; rs = a; rt = b; reset = r;
        @(negedge clk);
        st = stall;
        rd = rd_data;
        if (chk) begin
            e_busy = (m_cnt > 0);
            e_rd = 32'd0;
            if (v && !e_busy && o == 3'd6) e_rd = m_hi;
            if (v && !e_busy && o == 3'd7) e_rd = m_lo;
            check_eq("busy", {31'd0, busy}, {31'd0, e_busy});
            check_eq("stall", {31'd0, stall}, {31'd0, v && e_busy});
            check_eq("rd_data", rd_data, e_rd);
            check_eq("hi", hi, m_hi);
            check_eq("lo", lo, m_lo);
        end
        @(posedge clk);
        if (r) begin
            m_hi = 32'd0; m_lo = 32'd0; m_cnt = 0;
        end else if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_hi = p_hi; m_lo = p_lo;
            end
        end else if (v) begin
            case (o)
                3'd0, 3'd1: begin model_result(o, a, b); m_cnt = MC; end
                3'd2, 3'd3: begin
                    model_result(o, a, b);
                    m_cnt = (Div0Early && b == 32'd0) ? 1 : 33;
                end
                3'd4: m_hi = a;
                3'd5: m_lo = a;
                default: ;
            endcase
        end
        #1;
    endtask

    // Issue an op, then hold a read op until accepted; returns stall count and read data.
    task automatic issue_and_read(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                  input logic [2:0] rd_op, output int n_stall,
                                  output logic [31:0] rd);
        logic st;
        step(1'b1, o, a, b, 1'b0, 1'b1, st, rd);
        n_stall = 0;
        for (int k = 0; k < 60; k++) begin
            step(1'b1, rd_op, 32'd0, 32'd0, 1'b0, 1'b1, st, rd);
            if (!st) break;
            n_stall++;
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom();
        endcase
    endfunction

    initial begin
        logic        st;
        logic [31:0] rd;
        int          n;

        // Reset; the first cycle's outputs are undefined so it goes unchecked.
        step(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b0, st, rd);
        step(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b1, st, rd);
        step(1'b1, 3'd7, 32'd0, 32'd0, 1'b0, 1'b1, st, rd);
        check_eq("reset_mflo_rd", rd, 32'd0);
        check_eq("reset_mflo_stall", {31'd0, st}, 32'd0);

        // MULT -2 * 3 with MFLO held while busy.
        issue_and_read(3'd0, 32'hFFFF_FFFE, 32'd3, 3'd7, n, rd);
        check_eq("mult_stall_cycles", n, MC);
        check_eq("mult_mflo", rd, 32'hFFFF_FFFA);
        check_eq("mult_hi", hi, 32'hFFFF_FFFF);

        // DIV -7 / 2 with MFHI held.
        issue_and_read(3'd2, 32'hFFFF_FFF9, 32'd2, 3'd6, n, rd);
        check_eq("div_stall_cycles", n, 33);
        check_eq("div_mfhi", rd, 32'hFFFF_FFFF);
        check_eq("div_lo", lo, 32'hFFFF_FFFD);

        issue_and_read(3'd3, 32'd100, 32'd7, 3'd7, n, rd);
        check_eq("divu_lo", rd, 32'd14);
        check_eq("divu_hi", hi, 32'd2);

        issue_and_read(3'd3, 32'd5, 32'd0, 3'd6, n, rd);
        check_eq("div0_stall_cycles", n, Div0Early ? 1 : 33);
        check_eq("div0_hi", rd, 32'd5);
        check_eq("div0_lo", lo, 32'hFFFF_FFFF);

        issue_and_read(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 3'd7, n, rd);
        check_eq("ovf_lo", rd, 32'h8000_0000);
        check_eq("ovf_hi", hi, 32'd0);

        // MTHI then MFHI on the next cycle.
        step(1'b1, 3'd4, 32'h1234_5678, 32'd0, 1'b0, 1'b1, st, rd);
        step(1'b1, 3'd6, 32'd0, 32'd0, 1'b0, 1'b1, st, rd);
        check_eq("mthi_mfhi", rd, 32'h1234_5678);
        check_eq("mthi_stall", {31'd0, st}, 32'd0);

        // Reset during divide step 10 discards the operation.
        step(1'b1, 3'd5, 32'hCAFE_0001, 32'd0, 1'b0, 1'b1, st, rd);
        step(1'b1, 3'd2, 32'd1000, 32'd3, 1'b0, 1'b1, st, rd);
        for (int k = 0; k < 9; k++) step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1, st, rd);
        step(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b1, st, rd);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_hi", hi, 32'd0);
        check_eq("rst_lo", lo, 32'd0);
        issue_and_read(3'd0, 32'd3, 32'd4, 3'd7, n, rd);
        check_eq("post_rst_lo", rd, 32'd12);
        check_eq("post_rst_hi", hi, 32'd0);

        // Randomized traffic including occasional resets.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)), pick(), pick(),
                 ($urandom_range(0, 299) == 0), 1'b1, st, rd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/md_sequencer.md
# md_sequencer

Multi-cycle multiply/divide sequencer for the EX stage. Owns the HI/LO registers, accepts one HI/LO-class operation per cycle from the EX-stage instruction, runs multiplies through a fixed-latency countdown and divides through a 32-step iterative restoring divider, and raises `stall` so the hazard unit freezes EX and earlier stages while a new HI/LO-class op cannot be accepted.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy cycles for MULT/MULTU, legal range 1..15.

Ports:
- `clk` in 1: system clock, rising-edge.
- `reset` in 1: synchronous, active-high.
- `op_valid` in 1: EX presents a HI/LO-class op this cycle.
- `op` in 3: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MFHI, 7 MFLO.
- `rs` in 32: forwarded rs operand.
- `rt` in 32: forwarded rt operand.
- `stall` out 1: `op_valid && busy`; EX and earlier stages must hold.
- `busy` out 1: an operation is in flight.
- `rd_data` out 32: HI for MFHI, LO for MFLO on an accepted op, otherwise 0.
- `hi` out 32: architectural HI.
- `lo` out 32: architectural LO.

## Operation
- Reset: the FSM goes to IDLE. `hi`, `lo`, counter, and operand latches clear to 0. `busy`, `stall`, and `rd_data` are 0.
- Accept: an op is accepted when `op_valid && !busy`. Nothing is accepted while `busy`; EX is stalled.
- States and transitions:
  - IDLE: accept MULT/MULTU, go to MUL. Accept DIV/DIVU, go to DIV.
  - IDLE: accept MTHI, write `hi<=rs` at the clock edge and stay in IDLE. MTLO writes `lo<=rs` the same way.
  - IDLE: accept MFHI/MFLO, drive `rd_data` combinationally in the same cycle and stay in IDLE.
  - MUL: operands are latched at issue. The counter loads `MULT_CYCLES-1` and decrements each cycle. When it reaches 0, write `{hi,lo}` with the 64-bit product (signed for MULT, unsigned for MULTU) and go to IDLE.
  - DIV: latch the magnitudes of `rs` and `rt` (DIV) or the raw values (DIVU), plus the sign flags. Perform 32 restoring shift-subtract steps, one per cycle, then go to FIX.
  - FIX: DIV negates the quotient if the operand signs differ and gives the remainder the sign of the dividend. Write `lo`=quotient and `hi`=remainder, then go to IDLE.
- Divide by zero: `hi`=`rs` as issued, `lo`=32'hFFFFFFFF, for both DIV and DIVU. This is a special case in FIX.
- Arithmetic:
  - Magnitude of 32'h80000000 is 32'h80000000, treated as unsigned.
  - 32'h80000000 DIV 32'hFFFFFFFF gives `lo`=32'h80000000, `hi`=0.
- `busy` is a registered state decode: high in MUL, DIV, and FIX.

## Timing
- Issue at cycle T; operands are sampled at the T edge.
- MULT/MULTU:
  - `busy` is high for cycles T+1..T+`MULT_CYCLES`.
  - The new `hi`/`lo` are visible from T+`MULT_CYCLES`+1.
- DIV/DIVU:
  - `busy` is high for T+1..T+33 (32 steps plus FIX).
  - The new `hi`/`lo` are visible from T+34.
- MTHI/MTLO: takes effect at T+1; no busy cycles.
- MFHI/MFLO: zero latency; `rd_data` reflects `hi`/`lo` of cycle T.
- Back-to-back ops: a new op can be accepted in the first cycle `busy`=0, the same cycle the results become visible. An MFHI there reads the new value.
- Reset at any point, including mid-DIV or mid-MUL, aborts the operation. `hi`/`lo` end at 0 with no partial write, and the FSM returns to IDLE the next cycle.
- `op_valid` with `op` held stable during `stall` must be accepted exactly once, on the first non-busy cycle.

## Configuration
- Macro: `MD_SEQ_DIV0_EARLY_EN`.
- Defined: on issue of DIV/DIVU with `rt`==0, skip DIV and go straight to FIX. `busy` lasts 1 cycle (T+1) and results are visible at T+2.
- Undefined: divide by zero takes the full 33 busy cycles.
- Result values are identical in both builds.

## Test plan
- Reset then idle: `hi`=`lo`=0, `busy`=0; MFLO with `op_valid` -> `rd_data`=0, `stall`=0.
- MULT, `rs`=32'hFFFFFFFE, `rt`=3, `MULT_CYCLES`=5:
  - `busy` high for 5 cycles.
  - Then `hi`=32'hFFFFFFFF, `lo`=32'hFFFFFFFA.
  - MFLO held during `busy` -> `stall`=1 each cycle, accepted once with `rd_data`=32'hFFFFFFFA.
- DIV, `rs`=-7, `rt`=2:
  - 33 busy cycles.
  - Then `lo`=32'hFFFFFFFD (-3), `hi`=32'hFFFFFFFF (-1).
  - DIVU with 100 / 7 -> `lo`=14, `hi`=2.
- DIVU, `rs`=5, `rt`=0: `hi`=5, `lo`=32'hFFFFFFFF after 33 cycles, or after 1 cycle with `MD_SEQ_DIV0_EARLY_EN`.
- MTHI 32'h12345678, then MFHI next cycle -> `rd_data`=32'h12345678 with no stall.
- Reset asserted at DIV step 10 -> next cycle `busy`=0, `hi`=`lo`=0; a subsequent MULT 3*4 -> `lo`=12, `hi`=0.
